key_bounce_gen: RTL

- Generates a realistic mechanical-key waveform (press bounce, stable hold, release bounce, idle gap) on a single active-high level output.
- Sits on the driving side of the raw key line, in place of a physical button.
- Used for board self-test and hardware-in-loop checks of key debouncing paths.
- A one-cycle request produces one complete press/release waveform.

---
 rtl/key_bounce_gen.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/key_bounce_gen.sv
// Mechanical key emulator: press bounce, stable hold, release bounce and idle gap on key_o.
// Define KEY_BOUNCE_RANDOM_EN for LFSR-derived bounce segment lengths; otherwise they are BOUNCE_FIXED cycles.
module key_bounce_gen #(
   parameter int unsigned BOUNCE_PULSES = 3,
   parameter int unsigned BOUNCE_BITS   = 12,
`ifdef KEY_BOUNCE_RANDOM_EN
   parameter logic [15:0] LFSR_SEED     = 16'hACE1,
`else
   parameter int unsigned BOUNCE_FIXED  = 1000,
`endif
   parameter int unsigned HOLD_TIME     = 2400000,
   parameter int unsigned GAP_TIME      = 2400000,
   parameter int unsigned BITS          = 22
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic press_req,
   output logic key_o,
   output logic busy,
   output logic pending,
   output logic release_done
);

   localparam int unsigned SEGS        = 2 * BOUNCE_PULSES - 1;
   localparam int unsigned SEG_W       = $clog2(SEGS + 1);
   localparam int unsigned LAST_SEG    = SEGS - 1;
   localparam int unsigned REL_LAST_HI = (SEGS >= 2) ? SEGS - 2 : 0;
   localparam int unsigned HOLD_LAST   = HOLD_TIME - 1;
   localparam int unsigned GAP_LAST    = GAP_TIME - 1;

   typedef enum logic [2:0] {IDLE, PRESS_B, HOLD, REL_B, GAP} state_t;

   state_t             state, state_n;
   logic [BITS-1:0]    count, count_n;
   logic [SEG_W-1:0]   seg, seg_n;
   logic               key_n, busy_n, pending_n, rd_n;
   logic               start_c, gap_end_c, seg_end_c;

`ifdef KEY_BOUNCE_RANDOM_EN
   logic [15:0]            lfsr;
   logic [BOUNCE_BITS-1:0] seg_last;
   logic                   seg_start_c;

   // A bounce segment begins whenever the counter restarts inside a bounce phase
   assign seg_start_c = (count_n == '0) && ((state_n == PRESS_B) || (state_n == REL_B));
   assign seg_end_c   = (count == BITS'(seg_last));

   // Galois LFSR x^16+x^14+x^13+x^11+1, free-running in every state
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         lfsr     <= LFSR_SEED;
         seg_last <= '0;
      end else begin
         lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
         if (seg_start_c) seg_last <= lfsr[BOUNCE_BITS-1:0];
      end
   end
`else
   localparam int unsigned FIXED_LAST = (BOUNCE_FIXED <= (2 ** BOUNCE_BITS)) ?
                                        BOUNCE_FIXED - 1 : (2 ** BOUNCE_BITS) - 1;
   assign seg_end_c = (count == BITS'(FIXED_LAST));
`endif

   assign gap_end_c = (count == BITS'(GAP_LAST));

   // State and registered outputs
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state        <= IDLE;
         count        <= '0;
         seg          <= '0;
         key_o        <= 1'b0;
         busy         <= 1'b0;
         pending      <= 1'b0;
         release_done <= 1'b0;
      end else begin
         state        <= state_n;
         count        <= count_n;
         seg          <= seg_n;
         key_o        <= key_n;
         busy         <= busy_n;
         pending      <= pending_n;
         release_done <= rd_n;
      end
   end

   // Next state and next output values
   always_comb begin
      state_n   = state;
      count_n   = count;
      seg_n     = seg;
      key_n     = key_o;
      pending_n = pending;
      rd_n      = 1'b0;
      start_c   = 1'b0;

      case (state)
         IDLE: begin
            key_n = 1'b0;
            if (press_req) start_c = 1'b1;
         end
         PRESS_B: begin
            if (seg_end_c) begin
               count_n = '0;
               if (seg == SEG_W'(LAST_SEG)) begin
                  state_n = HOLD;
                  key_n   = 1'b1;
               end else begin
                  seg_n = seg + SEG_W'(1);
                  key_n = seg[0];
               end
            end else begin
               count_n = count + BITS'(1);
            end
         end
         HOLD: begin
            if (count == BITS'(HOLD_LAST)) begin
               count_n = '0;
               seg_n   = '0;
               key_n   = 1'b0;
               if (SEGS == 1) begin
                  state_n = GAP;
                  rd_n    = 1'b1;
               end else begin
                  state_n = REL_B;
               end
            end else begin
               count_n = count + BITS'(1);
            end
         end
         REL_B: begin
            if (seg_end_c) begin
               count_n = '0;
               if (seg == SEG_W'(REL_LAST_HI)) begin
                  // Final low segment is folded into the gap
                  state_n = GAP;
                  key_n   = 1'b0;
                  rd_n    = 1'b1;
               end else begin
                  seg_n = seg + SEG_W'(1);
                  key_n = ~seg[0];
               end
            end else begin
               count_n = count + BITS'(1);
            end
         end
         GAP: begin
            if (gap_end_c) begin
               if (pending) begin
                  pending_n = 1'b0;
                  start_c   = 1'b1;
               end else if (press_req) begin
                  start_c = 1'b1;
               end else begin
                  state_n = IDLE;
                  count_n = '0;
               end
            end else begin
               count_n = count + BITS'(1);
            end
         end
         default: begin
            state_n = IDLE;
            count_n = '0;
            seg_n   = '0;
            key_n   = 1'b0;
         end
      endcase

      // Queue at most one request behind the running waveform
      if (press_req && (state != IDLE) && !pending && !((state == GAP) && gap_end_c))
         pending_n = 1'b1;

      if (start_c) begin
         state_n = PRESS_B;
         count_n = '0;
         seg_n   = '0;
         key_n   = 1'b1;
      end

      busy_n = (state_n != IDLE);
   end

endmodule
